mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the IF-stage fetch and the MEM-stage data access of the RV32 pipeline.
//  Fixed-latency memory; FSM sequences one access at a time; DM has priority, with an IF anti-starvation override.
//  Drives if_stall / dm_stall into the hazard logic.
//  Supports cancelling an in-flight fetch on a taken branch.
// PARAMETERS
//  AW          17  word-address width
//  DW          32  data width
//  LAT         2   memory read latency in cycles, >=1 (rdata valid LAT cycles after mem_req)
//  STARVE_MAX  4   consecutive DM grants with IF pending before IF is forced (>=1)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active-low (0 = reset)
//  if_req     in   1      fetch request; held stable until if_valid or if_kill
//  if_addr    in   AW     fetch word address
//  if_kill    in   1      cancel pending/in-flight fetch (branch taken)
//  if_rdata   out  DW     fetched word, registered
//  if_valid   out  1      1-cycle fetch completion pulse
//  if_stall   out  1      if_req & ~if_valid & ~if_kill
//  dm_req     in   1      data request; held stable until dm_valid
//  dm_we      in   1      1 = store
//  dm_width   in   3      funct3 width code, passed through
//  dm_addr    in   AW     data word address
//  dm_wdata   in   DW     store data
//  dm_rdata   out  DW     load data, registered; 0 after a store
//  dm_valid   out  1      1-cycle data completion pulse (loads and stores)
//  dm_stall   out  1      dm_req & ~dm_valid
//  mem_req    out  1      1-cycle access strobe to memory
//  mem_we     out  1      store strobe, qualified by mem_req
//  mem_width  out  3      width to memory
//  mem_addr   out  AW     address to memory, held from grant until RESP
//  mem_wdata  out  DW     store data to memory
//  mem_rdata  in   DW     memory read data, sampled LAT cycles after mem_req
// BEHAVIOUR
//  States: IDLE, WAIT, RESP; owner register: IF or DM.
//  IDLE:
//   - grant when a request is present; mem_req=1 that cycle; go to WAIT with cnt=LAT-1.
//   - Winner: DM if dm_req, unless starve_cnt==STARVE_MAX and if_req.
//   - if_kill=1 masks if_req in that cycle.
//  WAIT:
//   - cnt decrements; when cnt==0, capture mem_rdata into the owner's rdata and go to RESP.
//   - cnt==0 is exactly T+LAT for a grant at T.
//  RESP:
//   - owner's valid=1 for one cycle; no grant this cycle; next state IDLE.
//   - Latency: grant T -> valid T+LAT+1. Throughput: one access per LAT+2 cycles.
//  starve_cnt: +1 (saturating at STARVE_MAX) on each DM grant while if_req & ~if_kill; cleared on IF grant.
//  if_kill during WAIT/RESP with owner=IF: kill_pend is set and the FSM still waits out the latency.
//   - With kill_pend, if_valid is suppressed and if_rdata is not updated.
//   - kill_pend clears in IDLE.
//  Store: mem_we=1 at grant. Store completes through WAIT/RESP like a load; dm_rdata<=0.
//  Requester changing addr/data while stalled: ignored; values latched at grant.
//  Reset (rst=0), including mid-access:
//   - state<=IDLE; cnt, starve_cnt, kill_pend <= 0.
//   - if_rdata/dm_rdata <= 0; if_valid, dm_valid, mem_req, mem_we <= 0.
//   - In-flight response is discarded; a store already strobed is not undone.
//  mem_addr/mem_width/mem_wdata reset to 0.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined:
//   - adds outputs perf_if_stall_cnt[31:0] and perf_dm_stall_cnt[31:0].
//   - Each counts cycles its stall is high; wraps at 2^32; cleared by rst.
//  MEM_ARB_PERF_EN undefined: these ports and counters do not exist; all other behaviour identical.
// TESTING (LAT=2, STARVE_MAX=4 unless stated)
//  1. rst=0 for 2 cycles with both reqs high:
//     -> mem_req=0, valids=0, rdata=0; first grant in the first cycle with rst=1.
//  2. IF-only read, if_addr=0x10 at T; mem_rdata=0xDEADBEEF at T+2:
//     -> mem_req@T, mem_addr=0x10; if_stall T..T+2; if_valid@T+3 with if_rdata=0xDEADBEEF.
//  3. if_req(0x04) and dm_req load(0x20) both at T:
//     -> DM granted at T, dm_valid@T+3; IF granted T+4, if_valid@T+7.
//  4. STARVE_MAX=2; dm_req held continuously, if_req held:
//     -> DM grants at T, T+4; IF grant at T+8; DM resumes at T+12.
//  5. Store dm_addr=0x30, wdata=0x12345678:
//     -> mem_we=1 only at grant; dm_valid@T+3 with dm_rdata=0.
//  6. IF grant at T, if_kill at T+1:
//     -> no if_valid; FSM back in IDLE at T+4.
//     With rst=0 at T+1 instead: IDLE at T+2, no valid; perf counters=0 when MEM_ARB_PERF_EN.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between instruction fetch and data access.
// Define MEM_ARB_PERF_EN to add the stall-cycle performance counters.
module mem_port_arbiter #(
  parameter int unsigned AW         = 17,
  parameter int unsigned DW         = 32,
  parameter int unsigned LAT        = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [2:0]    dm_width,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [2:0]    mem_width,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_if_stall_cnt,
  output logic [31:0]   perf_dm_stall_cnt
`endif
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  // Fetches are always full words and carry no store data.
  localparam logic [2:0] FETCH_WIDTH = 3'b010;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic          owner_dm;
  logic          owner_we;
  logic          kill_pend;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve_cnt;
  logic [AW-1:0] addr_q;
  logic [2:0]    width_q;
  logic [DW-1:0] wdata_q;

  logic if_live;
  logic grant;
  logic win_if;

  // Grant decision: DM first unless IF has been passed over STARVE_MAX times.
  always_comb begin
    if_live = if_req & ~if_kill;
    grant   = rst & (state == IDLE) & (dm_req | if_live);
    win_if  = if_live & (~dm_req | (starve_cnt == SW'(STARVE_MAX)));
  end

  // The strobe and the granted requester's fields go out in the grant cycle, then hold.
  assign mem_req   = grant;
  assign mem_we    = grant & ~win_if & dm_we;
  assign mem_addr  = grant ? (win_if ? if_addr : dm_addr) : addr_q;
  assign mem_width = grant ? (win_if ? FETCH_WIDTH : dm_width) : width_q;
  assign mem_wdata = grant ? (win_if ? '0 : dm_wdata) : wdata_q;

  assign if_stall = if_req & ~if_valid & ~if_kill;
  assign dm_stall = dm_req & ~dm_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner_dm   <= 1'b0;
      owner_we   <= 1'b0;
      kill_pend  <= 1'b0;
      cnt        <= '0;
      starve_cnt <= '0;
      addr_q     <= '0;
      width_q    <= '0;
      wdata_q    <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          kill_pend <= 1'b0;
          if (grant) begin
            state    <= WAIT;
            cnt      <= CW'(LAT - 1);
            owner_dm <= ~win_if;
            owner_we <= ~win_if & dm_we;
            addr_q   <= mem_addr;
            width_q  <= mem_width;
            wdata_q  <= mem_wdata;
            if (win_if) begin
              starve_cnt <= '0;
            end else if (if_live && (starve_cnt != SW'(STARVE_MAX))) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end
        end
        WAIT: begin
          if (!owner_dm && if_kill) kill_pend <= 1'b1;
          if (cnt == '0) begin
            state <= RESP;
            if (owner_dm) begin
              dm_valid <= 1'b1;
              dm_rdata <= owner_we ? '0 : mem_rdata;
            end else if (!(kill_pend || if_kill)) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          // A kill this late finds the pulse already out; the flag is dropped in IDLE.
          if (!owner_dm && if_kill) kill_pend <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Stall-cycle counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_if_stall_cnt <= '0;
      perf_dm_stall_cnt <= '0;
    end else begin
      perf_if_stall_cnt <= perf_if_stall_cnt + 32'(if_stall);
      perf_dm_stall_cnt <= perf_dm_stall_cnt + 32'(dm_stall);
    end
  end
`endif

endmodule
